// File: rtl/pipe_field.sv
// Pipe field: N_PIPE scrolling pipe gaps with LFSR recycling, collision detection and scoring.
// Optional macro PIPE_FIELD_SPEEDUP_EN shortens the scroll period every 8 points scored.
module pipe_field #(
  parameter int unsigned N_PIPE     = 3,
  parameter int unsigned SPACING    = 50,
  parameter int unsigned SCROLL_DIV = 1,
  parameter int unsigned GAP        = 10,
  parameter int unsigned GAP_FLOOR  = 8,
  parameter int unsigned GAP_MASK   = 15,
  parameter int unsigned BIRD_COL   = 4,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [7:0]            bird_alt,
  output logic [24*N_PIPE-1:0]  pipes,
  output logic                  collide,
  output logic [15:0]           score,
  output logic                  score_pulse
);

  localparam logic [7:0] RecyclePos = 8'(N_PIPE * SPACING);
  localparam logic [7:0] GapFloor   = 8'(GAP_FLOOR);
  localparam logic [7:0] GapWidth   = 8'(GAP);
  localparam logic [7:0] GapMask    = 8'(GAP_MASK);
  localparam logic [7:0] BirdCol    = 8'(BIRD_COL);
  localparam logic [8:0] BirdCol9   = 9'(BIRD_COL);
  localparam logic [3:0] DivReset   = 4'(SCROLL_DIV);

  logic [7:0]  pos_q [N_PIPE];
  logic [7:0]  pos_d [N_PIPE];
  logic [7:0]  min_q [N_PIPE];
  logic [7:0]  min_d [N_PIPE];
  logic [7:0]  max_q [N_PIPE];
  logic [7:0]  max_d [N_PIPE];
  logic [7:0]  lfsr_q, lfsr_d, lfsr_next;
  logic [3:0]  div_q, div_d;
  logic        collide_q, collide_d;
  logic [15:0] score_q, score_d;
  logic        pulse_q, pulse_d;

  logic [7:0]  new_min, new_max;
  logic [16:0] score_sum;
  logic [3:0]  n_score;
  logic        step, any_recycle, win_hit, hit;
  logic [8:0]  pos9;

`ifdef PIPE_FIELD_SPEEDUP_EN
  logic [3:0] div_limit_q, div_limit_d;
  logic [3:0] div_limit;
  assign div_limit = div_limit_q;
`else
  logic [3:0] div_limit;
  assign div_limit = DivReset;
`endif

  always_comb begin
    step        = run & ~collide_q & (div_q == div_limit - 4'd1);
    lfsr_next   = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    new_min     = GapFloor + (lfsr_next & GapMask);
    new_max     = new_min + GapWidth;
    any_recycle = 1'b0;
    win_hit     = 1'b0;
    n_score     = 4'd0;
    pos9        = 9'd0;
    for (int unsigned i = 0; i < N_PIPE; i++) begin
      pos_d[i] = pos_q[i];
      min_d[i] = min_q[i];
      max_d[i] = max_q[i];
      if (step) begin
        if (pos_q[i] == 8'd0) begin
          // All pipes recycled on the same step share one LFSR advance.
          pos_d[i]    = RecyclePos;
          min_d[i]    = new_min;
          max_d[i]    = new_max;
          any_recycle = 1'b1;
        end else begin
          pos_d[i] = pos_q[i] - 8'd1;
        end
        if (pos_d[i] == BirdCol) n_score = n_score + 4'd1;
      end
      pos9 = {1'b0, pos_q[i]};
      if ((pos9 + 9'd2 >= BirdCol9) && (pos9 <= BirdCol9 + 9'd2) &&
          ((bird_alt <= min_q[i]) || (bird_alt >= max_q[i]))) begin
        win_hit = 1'b1;
      end
    end

    lfsr_d    = any_recycle ? lfsr_next : lfsr_q;
    hit       = run & (win_hit | (bird_alt == 8'd0));
    collide_d = collide_q | hit;
    score_sum = {1'b0, score_q} + 17'(n_score);
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    pulse_d   = (n_score != 4'd0);

    div_d = div_q;
    if (run && !collide_q) div_d = step ? 4'd0 : div_q + 4'd1;

`ifdef PIPE_FIELD_SPEEDUP_EN
    div_limit_d = div_limit_q;
    // Crossing a multiple of 8 shows up as a change in the upper score bits.
    if (score_d[15:3] != score_q[15:3]) begin
      div_limit_d = (div_limit_q > 4'd1) ? div_limit_q - 4'd1 : 4'd1;
      div_d       = 4'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_PIPE; i++) begin
        pos_q[i] <= 8'((i + 1) * SPACING);
        min_q[i] <= GapFloor;
        max_q[i] <= GapFloor + GapWidth;
      end
      lfsr_q    <= LFSR_SEED;
      div_q     <= 4'd0;
      collide_q <= 1'b0;
      score_q   <= 16'd0;
      pulse_q   <= 1'b0;
`ifdef PIPE_FIELD_SPEEDUP_EN
      div_limit_q <= DivReset;
`endif
    end else begin
      for (int unsigned i = 0; i < N_PIPE; i++) begin
        pos_q[i] <= pos_d[i];
        min_q[i] <= min_d[i];
        max_q[i] <= max_d[i];
      end
      lfsr_q    <= lfsr_d;
      div_q     <= div_d;
      collide_q <= collide_d;
      score_q   <= score_d;
      pulse_q   <= pulse_d;
`ifdef PIPE_FIELD_SPEEDUP_EN
      div_limit_q <= div_limit_d;
`endif
    end
  end

  always_comb begin
    pipes = '0;
    for (int unsigned i = 0; i < N_PIPE; i++) begin
      pipes[24*i +: 24] = {pos_q[i], max_q[i], min_q[i]};
    end
  end

  assign collide     = collide_q;
  assign score       = score_q;
  assign score_pulse = pulse_q;

endmodule

// File: tb/tb_pipe_field.sv
// Bench for pipe_field: phase table with hand-derived expectations plus a per-cycle
// scoreboard for positions, score and score_pulse on the non-colliding phases.
module tb_pipe_field;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [7:0]  bird_alt;
  logic [71:0] pipes, pipes3;
  logic        collide, collide3, score_pulse, pulse3;
  logic [15:0] score, score3;

  always #5 clk = ~clk;

  pipe_field u_dut (
    .clk(clk), .rst(rst), .run(run), .bird_alt(bird_alt),
    .pipes(pipes), .collide(collide), .score(score), .score_pulse(score_pulse)
  );

  pipe_field #(.SCROLL_DIV(3)) u_dut_d3 (
    .clk(clk), .rst(rst), .run(run), .bird_alt(bird_alt),
    .pipes(pipes3), .collide(collide3), .score(score3), .score_pulse(pulse3)
  );

  typedef struct {
    logic       rst;
    logic       run;
    logic [7:0] bird;
    int         ncyc;
    logic       sb;
    int pos0, min0, max0, pos1, min1, max1, pos2, sc, coll, d3pos0;
  } vec_t;

  typedef struct {
    logic en;
    int   p0, p1, p2, sc;
    logic pl;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   m_pos[3];
  int   m_score;
  int   checks = 0;
  int   errors = 0;

  function automatic int fpos(input logic [71:0] b, input int i);
    return int'(b[24*i+16 +: 8]);
  endfunction
  function automatic int fmax(input logic [71:0] b, input int i);
    return int'(b[24*i+8 +: 8]);
  endfunction
  function automatic int fmin(input logic [71:0] b, input int i);
    return int'(b[24*i +: 8]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rn, input logic [7:0] b, input int n,
                     input logic sb, input int p0, input int mn0, input int mx0,
                     input int p1, input int mn1, input int mx1, input int p2,
                     input int sc, input int co, input int d3);
    vec_t v;
    v.rst = r; v.run = rn; v.bird = b; v.ncyc = n; v.sb = sb;
    v.pos0 = p0; v.min0 = mn0; v.max0 = mx0; v.pos1 = p1; v.min1 = mn1; v.max1 = mx1;
    v.pos2 = p2; v.sc = sc; v.coll = co; v.d3pos0 = d3;
    vecs.push_back(v);
  endtask

  // Model the upcoming edge, queue its expectation, then compare once the DUT has clocked.
  task automatic tick(input logic sb_en);
    exp_t e;
    logic any = 1'b0;
    if (rst) begin
      m_pos[0] = 50; m_pos[1] = 100; m_pos[2] = 150; m_score = 0;
    end else if (run) begin
      for (int i = 0; i < 3; i++) begin
        m_pos[i] = (m_pos[i] == 0) ? 150 : m_pos[i] - 1;
        if (m_pos[i] == 4) begin
          any = 1'b1;
          if (m_score < 65535) m_score++;
        end
      end
    end
    e.en = sb_en; e.p0 = m_pos[0]; e.p1 = m_pos[1]; e.p2 = m_pos[2];
    e.sc = m_score; e.pl = any;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    if (e.en) begin
      chk("sb_pos0", fpos(pipes, 0), e.p0);
      chk("sb_pos1", fpos(pipes, 1), e.p1);
      chk("sb_pos2", fpos(pipes, 2), e.p2);
      chk("sb_score", int'(score), e.sc);
      chk("sb_pulse", int'(score_pulse), int'(e.pl));
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; bird_alt = 8'd13;
    m_pos[0] = 50; m_pos[1] = 100; m_pos[2] = 150; m_score = 0;

    //   rst run bird  n  sb  pos0 mn0 mx0 pos1 mn1 mx1 pos2 sc co d3
    add(1, 0, 13,  2, 1,  50,  8, 18, 100,  8, 18, 150, 0, 0, 50);
    add(0, 1, 13, 46, 1,   4,  8, 18,  54,  8, 18, 104, 1, 0, 35);
    add(0, 0, 13, 10, 1,   4,  8, 18,  54,  8, 18, 104, 1, 0, 35);
    add(0, 1, 13,  1, 1,   3,  8, 18,  53,  8, 18, 103, 1, 0, 35);
    add(0, 1, 13,  1, 1,   2,  8, 18,  52,  8, 18, 102, 1, 0, 34);
    add(0, 1, 13,  3, 1, 150, 18, 28,  49,  8, 18,  99, 1, 0, 33);
    add(1, 1, 13,  1, 1,  50,  8, 18, 100,  8, 18, 150, 0, 0, 50);
    add(0, 1, 13, 51, 1, 150, 18, 28,  49,  8, 18,  99, 1, 0, 33);
    add(0, 1, 13, 50, 1, 100, 18, 28, 150, 13, 23,  49, 2, 0, 17);
    add(1, 0, 20,  1, 0,  50,  8, 18, 100,  8, 18, 150, 0, 0, 50);
    add(0, 1, 20, 44, 0,   6,  8, 18,  56,  8, 18, 106, 0, 0, 36);
    add(0, 1, 20,  1, 0,   5,  8, 18,  55,  8, 18, 105, 0, 1, 35);
    add(0, 1, 20,  5, 0,   5,  8, 18,  55,  8, 18, 105, 0, 1, 34);
    add(0, 0, 13,  3, 0,   5,  8, 18,  55,  8, 18, 105, 0, 1, 34);
    add(1, 0, 13,  1, 0,  50,  8, 18, 100,  8, 18, 150, 0, 0, 50);
    add(0, 0,  0,  3, 0,  50,  8, 18, 100,  8, 18, 150, 0, 0, 50);
    add(0, 1,  0,  1, 0,  49,  8, 18,  99,  8, 18, 149, 0, 1, 50);
    add(0, 1,  0,  3, 0,  49,  8, 18,  99,  8, 18, 149, 0, 1, 50);

    tick(1'b0);
    tick(1'b0);
    chk("reset_bus_pipe2", int'(pipes[71:48]), 24'h961208);
    chk("reset_bus_pipe1", int'(pipes[47:24]), 24'h641208);
    chk("reset_bus_pipe0", int'(pipes[23:0]),  24'h321208);
    chk("reset_pulse", int'(score_pulse), 0);

    for (int r = 0; r < vecs.size(); r++) begin
      rst = vecs[r].rst; run = vecs[r].run; bird_alt = vecs[r].bird;
      repeat (vecs[r].ncyc) tick(vecs[r].sb);
      chk($sformatf("r%0d_pos0", r), fpos(pipes, 0), vecs[r].pos0);
      chk($sformatf("r%0d_min0", r), fmin(pipes, 0), vecs[r].min0);
      chk($sformatf("r%0d_max0", r), fmax(pipes, 0), vecs[r].max0);
      chk($sformatf("r%0d_pos1", r), fpos(pipes, 1), vecs[r].pos1);
      chk($sformatf("r%0d_min1", r), fmin(pipes, 1), vecs[r].min1);
      chk($sformatf("r%0d_max1", r), fmax(pipes, 1), vecs[r].max1);
      chk($sformatf("r%0d_pos2", r), fpos(pipes, 2), vecs[r].pos2);
      chk($sformatf("r%0d_score", r), int'(score), vecs[r].sc);
      chk($sformatf("r%0d_collide", r), int'(collide), vecs[r].coll);
      chk($sformatf("r%0d_d3_pos0", r), fpos(pipes3, 0), vecs[r].d3pos0);
    end

    // rst wins over run and a ground hit in the same cycle; the hit lands once rst drops.
    rst = 1'b1; run = 1'b1; bird_alt = 8'd0;
    tick(1'b0);
    chk("rst_over_hit_collide", int'(collide), 0);
    chk("rst_over_hit_pos0", fpos(pipes, 0), 50);
    rst = 1'b0;
    tick(1'b0);
    chk("post_rst_hit_collide", int'(collide), 1);
    chk("post_rst_hit_pos0", fpos(pipes, 0), 49);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
